// File: rtl/reg_mem_2r1w.sv
// Register-file memory: one write port, two registered read ports, and a
// self-clearing sweep that zeroes the array after reset or on a clr request.
module reg_mem_2r1w #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren_a,
  input  logic [ADDR_BITS-1:0]  raddr_a,
  input  logic                  ren_b,
  input  logic [ADDR_BITS-1:0]  raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic                  clr,
  output logic                  busy,
  output logic                  wr_drop
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_BITS-1:0]  ptr, ptr_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_BITS-1:0]  mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  wr_ok;
  logic                  drop_nxt;
  logic [DATA_WIDTH-1:0] rd_nxt_a, rd_nxt_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SWEEP;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // The sweep borrows the single write port; user writes are dropped meanwhile.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    wr_ok     = 1'b0;
    drop_nxt  = 1'b0;
    case (state)
      SWEEP: begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = '0;
        drop_nxt  = wen;
        if (ptr == '1) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_nxt = SWEEP;
          ptr_nxt   = '0;
          drop_nxt  = wen;
        end else if (wen) begin
          mem_we = 1'b1;
          wr_ok  = 1'b1;
        end
      end
      default: state_nxt = SWEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rd_nxt_a = rdata_a;
    if (ren_a) begin
      if (state == SWEEP)                  rd_nxt_a = '0;
      else if (wr_ok && waddr == raddr_a)  rd_nxt_a = wdata;
      else                                 rd_nxt_a = mem[raddr_a];
    end
  end

  always_comb begin
    rd_nxt_b = rdata_b;
    if (ren_b) begin
      if (state == SWEEP)                  rd_nxt_b = '0;
      else if (wr_ok && waddr == raddr_b)  rd_nxt_b = wdata;
      else                                 rd_nxt_b = mem[raddr_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
      wr_drop <= 1'b0;
    end else begin
      rdata_a <= rd_nxt_a;
      rdata_b <= rd_nxt_b;
      wr_drop <= drop_nxt;
    end
  end

  assign busy = (state == SWEEP);

endmodule

// File: tb/tb_reg_mem_2r1w.sv
// Bench for reg_mem_2r1w: directed scenarios plus random traffic against an
// array-level reference model; a second small instance covers 16-bit/8-deep.
module tb_reg_mem_2r1w;

  localparam int DW    = 8;
  localparam int AB    = 5;
  localparam int DEPTH = 2 ** AB;
  localparam int DW_S  = 16;
  localparam int AB_S  = 3;

  logic          clk = 1'b0;
  logic          rst_n, wen, ren_a, ren_b, clr;
  logic [AB-1:0] waddr, raddr_a, raddr_b;
  logic [DW-1:0] wdata, rdata_a, rdata_b;
  logic          busy, wr_drop;

  logic            rst_n_s, wen_s, ren_a_s, ren_b_s, clr_s;
  logic [AB_S-1:0] waddr_s, raddr_a_s, raddr_b_s;
  logic [DW_S-1:0] wdata_s, rdata_a_s, rdata_b_s;
  logic            busy_s, wr_drop_s;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_sweep;
  logic [DW-1:0] exp_a, exp_b;
  logic          exp_drop;

  always #5 clk = ~clk;

  reg_mem_2r1w #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a), .raddr_a(raddr_a), .ren_b(ren_b), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .clr(clr), .busy(busy), .wr_drop(wr_drop)
  );

  reg_mem_2r1w #(.DATA_WIDTH(DW_S), .ADDR_BITS(AB_S)) dut_s (
    .clk(clk), .rst_n(rst_n_s), .wen(wen_s), .waddr(waddr_s), .wdata(wdata_s),
    .ren_a(ren_a_s), .raddr_a(raddr_a_s), .ren_b(ren_b_s), .raddr_b(raddr_b_s),
    .rdata_a(rdata_a_s), .rdata_b(rdata_b_s), .clr(clr_s), .busy(busy_s), .wr_drop(wr_drop_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_sweep  = DEPTH;
    exp_a    = '0;
    exp_b    = '0;
    exp_drop = 1'b0;
  endtask

  // One clock edge of the array's behaviour, in plain array terms.
  task automatic model_edge();
    if (m_sweep > 0) begin
      exp_drop = wen;
      if (ren_a) exp_a = '0;
      if (ren_b) exp_b = '0;
      m_sweep--;
    end else if (clr) begin
      exp_drop = wen;
      if (ren_a) exp_a = m_mem[raddr_a];
      if (ren_b) exp_b = m_mem[raddr_b];
      for (int unsigned i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_sweep = DEPTH;
    end else begin
      exp_drop = 1'b0;
      if (wen) m_mem[waddr] = wdata;
      if (ren_a) exp_a = m_mem[raddr_a];
      if (ren_b) exp_b = m_mem[raddr_b];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("busy", 32'(busy), 32'(m_sweep > 0));
    check("wr_drop", 32'(wr_drop), 32'(exp_drop));
    check("rdata_a", 32'(rdata_a), 32'(exp_a));
    check("rdata_b", 32'(rdata_b), 32'(exp_b));
  endtask

  task automatic idle_inputs();
    wen = 1'b0; ren_a = 1'b0; ren_b = 1'b0; clr = 1'b0;
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    logic [DW_S-1:0] v;

    idle_inputs();
    rst_n = 1'b0;
    rst_n_s = 1'b0;
    wen_s = 1'b0; ren_a_s = 1'b0; ren_b_s = 1'b0; clr_s = 1'b0;
    waddr_s = '0; wdata_s = '0; raddr_a_s = '0; raddr_b_s = '0;
    model_reset();
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rdata_a", 32'(rdata_a), 32'd0);
    check("rst_rdata_b", 32'(rdata_b), 32'd0);
    check("rst_drop", 32'(wr_drop), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    count_busy(n);
    check("init_sweep_len", 32'(n), 32'(DEPTH));

    for (int unsigned i = 0; i < DEPTH; i++) begin
      ren_a = 1'b1; raddr_a = AB'(i); ren_b = 1'b1; raddr_b = AB'(i);
      step();
      check("init_zero_a", 32'(rdata_a), 32'd0);
      check("init_zero_b", 32'(rdata_b), 32'd0);
    end
    idle_inputs();

    for (int unsigned i = 0; i < DEPTH; i++) begin
      wen = 1'b1; waddr = AB'(i); wdata = DW'(i + 10);
      step();
    end
    idle_inputs();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ren_a = 1'b1; raddr_a = AB'(i); ren_b = 1'b1; raddr_b = AB'(DEPTH - 1 - i);
      step();
      check("fill_a", 32'(rdata_a), 32'(i + 10));
      check("fill_b", 32'(rdata_b), 32'(DEPTH - 1 - i + 10));
    end
    idle_inputs();

    wen = 1'b1; waddr = 7; wdata = 8'hA5; ren_a = 1'b1; raddr_a = 7;
    step();
    check("bypass_a", 32'(rdata_a), 32'hA5);
    check("hold_b", 32'(rdata_b), 32'd10);
    idle_inputs();

    // clear after fill, with a write attempted mid-sweep
    clr = 1'b1;
    step();
    clr = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      wen = (n == 3); waddr = 3; wdata = 8'h77;
      ren_a = 1'b1; raddr_a = AB'($urandom); ren_b = 1'b1; raddr_b = 3;
      step();
      check("sweep_rd_a", 32'(rdata_a), 32'd0);
      check("sweep_rd_b", 32'(rdata_b), 32'd0);
      check("sweep_drop", 32'(wr_drop), 32'(n == 3));
    end
    check("clr_sweep_len", 32'(n), 32'(DEPTH));
    idle_inputs();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ren_a = 1'b1; raddr_a = AB'(i); ren_b = 1'b1; raddr_b = AB'(i);
      step();
      check("post_clr_a", 32'(rdata_a), 32'd0);
    end
    idle_inputs();

    for (int unsigned k = 0; k < 400; k++) begin
      wen = ($urandom_range(0, 1) == 1); waddr = AB'($urandom); wdata = DW'($urandom);
      ren_a = ($urandom_range(0, 3) != 0); raddr_a = AB'($urandom);
      ren_b = ($urandom_range(0, 3) != 0);
      raddr_b = ($urandom_range(0, 3) == 0) ? waddr : AB'($urandom);
      if ($urandom_range(0, 1) == 1) raddr_a = waddr;
      clr = ($urandom_range(0, 59) == 0);
      step();
    end
    idle_inputs();
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end

    // reset asserted partway through a sweep
    wen = 1'b1; waddr = 9; wdata = 8'h5A; ren_a = 1'b1; raddr_a = 9;
    step();
    idle_inputs();
    clr = 1'b1;
    step();
    clr = 1'b0;
    wen = 1'b1;
    repeat (12) step();
    check("pre_rst_a", 32'(rdata_a), 32'h5A);
    check("pre_rst_drop", 32'(wr_drop), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_rdata_a", 32'(rdata_a), 32'd0);
    check("mid_rst_drop", 32'(wr_drop), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n);
    check("rst_sweep_len", 32'(n), 32'(DEPTH));

    // 16-bit, 8-deep instance
    rst_n_s = 1'b1;
    n = 0;
    while (busy_s && n < 100) begin
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    check("s_sweep_len", 32'(n), 32'd8);
    for (int unsigned i = 0; i < 8; i++) begin
      wen_s = 1'b1; waddr_s = AB_S'(i);
      wdata_s = (i == 5) ? 16'hBEEF : DW_S'(16'h1000 + i);
      @(posedge clk);
      @(negedge clk);
    end
    wen_s = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      ren_a_s = 1'b1; raddr_a_s = AB_S'(i); ren_b_s = 1'b1; raddr_b_s = AB_S'(7 - i);
      @(posedge clk);
      @(negedge clk);
      v = (i == 5) ? 16'hBEEF : DW_S'(16'h1000 + i);
      check("s_rd_a", 32'(rdata_a_s), 32'(v));
      v = ((7 - i) == 5) ? 16'hBEEF : DW_S'(16'h1000 + 7 - i);
      check("s_rd_b", 32'(rdata_b_s), 32'(v));
    end
    check("s_drop", 32'(wr_drop_s), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_mem_2r1w.md
REG_MEM_2R1W -- requirements
Module: reg_mem_2r1w

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_BITS, default 5, address width; DEPTH = 2**ADDR_BITS words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wen  input  1  write enable.
REQ-006 SHALL have port waddr  input  ADDR_BITS  write address.
REQ-007 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-008 SHALL have port ren_a / ren_b  input  1 each  read enable, ports A and B.
REQ-009 SHALL have port raddr_a / raddr_b  input  ADDR_BITS each  read addresses.
REQ-010 SHALL have port rdata_a / rdata_b  output  DATA_WIDTH each  registered read data.
REQ-011 SHALL have port clr  input  1  request to zero the whole array.
REQ-012 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-013 SHALL have port wr_drop  output  1  one-cycle pulse when a write is discarded.

Function
REQ-014 SHALL hold DEPTH x DATA_WIDTH storage, one write port, two independent read ports.
REQ-015 SHALL have FSM states SWEEP and IDLE; busy = (state == SWEEP), decoded from state register.
REQ-016 In SWEEP, SHALL write 0 to mem[ptr] each cycle, ptr incrementing from 0; when ptr == DEPTH-1, SHALL write that last word and move to IDLE next edge; sweep lasts exactly DEPTH cycles.
REQ-017 In IDLE, clr = 1 SHALL move to SWEEP with ptr = 0 on the next edge; clr in SWEEP SHALL be ignored (no restart).
REQ-018 In IDLE, wen = 1 SHALL write wdata to mem[waddr] at the edge.
REQ-019 wen = 1 during SWEEP, or in the IDLE cycle where clr = 1, SHALL be discarded and wr_drop SHALL pulse high for the following cycle.
REQ-020 Read latency SHALL be 1 cycle: ren_x = 1 at edge N gives rdata_x valid after edge N.
REQ-021 ren_x = 0 SHALL hold rdata_x at its previous value.
REQ-022 Write-first bypass: if an accepted write and ren_x hit the same address in one cycle, rdata_x SHALL return wdata.
REQ-023 Both read ports MAY target the same address in one cycle; each SHALL return the same correct word.
REQ-024 Reads in SWEEP with ren_x = 1 SHALL return 0 regardless of address.
REQ-025 ptr SHALL be ADDR_BITS wide; no wrap beyond DEPTH-1 during a sweep.
REQ-026 The array SHALL NOT be asynchronously reset; zeroing occurs only via sweep.

Reset
REQ-027 rst_n = 0 SHALL asynchronously force state = SWEEP, ptr = 0, rdata_a = rdata_b = 0, wr_drop = 0; busy = 1.
REQ-028 After rst_n rises, the sweep SHALL run DEPTH cycles, then busy = 0; array contents all 0.
REQ-029 rst_n asserted mid-sweep or mid-operation SHALL restart the sweep from ptr = 0 after release.

Verification
REQ-030 Reset release, defaults: busy high exactly 32 cycles then low; reading addr 0..31 returns 0 on both ports.
REQ-031 Write 10..41 to addr 0..31, then read A ascending and B descending -> rdata_a = addr+10, rdata_b = addr+10, each 1 cycle after ren.
REQ-032 Same cycle wen = 1, waddr = 7, wdata = 0xA5, ren_a = 1, raddr_a = 7 -> rdata_a = 0xA5 next cycle; ren_b = 0 -> rdata_b unchanged.
REQ-033 clr pulse after fill -> busy high 32 cycles; write during sweep -> wr_drop pulse, write absent afterward; reads during sweep = 0; all 0 after.
REQ-034 rst_n low at sweep ptr = 12 -> outputs 0 immediately; after release busy lasts full 32 cycles.
REQ-035 Repeat REQ-031 with DATA_WIDTH = 16, ADDR_BITS = 3 -> 8-cycle sweep, wdata 0xBEEF round-trips exactly.
